sobel_edge_stream: RTL and testbench

- Downstream consumer of the per-pixel point-operation stage (brightness add/sub, threshold, invert).
- Takes that stage's 8-bit raster pixel stream and computes a 3x3 Sobel gradient magnitude for edge contouring of X-ray frames.
- Buffers two image lines internally.
- Emits one saturated 8-bit magnitude and one binary edge flag per interior pixel.

---
 rtl/sobel_edge_stream.sv | 175 +++++++++++++++++
 tb/tb_sobel_edge_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel gradient magnitude with two internal line buffers.
// Emits a saturated magnitude and an edge flag for every interior pixel of a raster frame.
//
// state  | meaning
// IDLE   | waiting for in_sof; pixels without in_sof are dropped
// ACTIVE | accepting pixels of a frame, row/col counters advancing
module sobel_edge_stream #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic [7:0] in_byte,
    input  logic [7:0] threshold,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic       out_edge,
    output logic       out_eof
);

    localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic [CW-1:0] col_q, col_d, cur_col;
    logic          accept;

    logic [7:0] lb1_q [IMG_WIDTH];
    logic [7:0] lb2_q [IMG_WIDTH];
    logic [7:0] win_q [3][3];
    logic       win_vld_q, win_eof_q;
    logic [7:0] win_thr_q;

    logic signed [10:0] gx_d, gy_d, gx_q, gy_q;
    logic               g_vld_q, g_eof_q;
    logic [7:0]         g_thr_q;

    logic [10:0] abs_x, abs_y, mag;
    logic [7:0]  sat;

    logic       out_valid_q, out_edge_q, out_eof_q;
    logic [7:0] out_byte_q;

    function automatic logic [9:0] tri_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        accept  = 1'b0;
        cur_row = row_q;
        cur_col = col_q;
        // A qualified in_sof always restarts at (0,0), even in the middle of a frame.
        if (in_valid && in_sof) begin
            accept  = 1'b1;
            cur_row = '0;
            cur_col = '0;
        end else if (in_valid && state_q == ACTIVE) begin
            accept = 1'b1;
        end
        if (accept) begin
            state_d = ACTIVE;
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            if (cur_row == ROW_LAST && cur_col == COL_LAST) begin
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Line buffers and window data carry no reset; only the valid flags gate their use.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[cur_col] <= in_byte;
            lb2_q[cur_col] <= lb1_q[cur_col];
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= win_q[i][2];
            end
            win_q[0][2] <= lb2_q[cur_col];
            win_q[1][2] <= lb1_q[cur_col];
            win_q[2][2] <= in_byte;
            win_thr_q   <= threshold;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_vld_q <= 1'b0;
            win_eof_q <= 1'b0;
        end else begin
            win_vld_q <= accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            win_eof_q <= accept && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end
    end

    always_comb begin
        gx_d = $signed({1'b0, tri_sum(win_q[0][2], win_q[1][2], win_q[2][2])})
             - $signed({1'b0, tri_sum(win_q[0][0], win_q[1][0], win_q[2][0])});
        gy_d = $signed({1'b0, tri_sum(win_q[2][0], win_q[2][1], win_q[2][2])})
             - $signed({1'b0, tri_sum(win_q[0][0], win_q[0][1], win_q[0][2])});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_vld_q <= 1'b0;
            g_eof_q <= 1'b0;
            g_thr_q <= '0;
            gx_q    <= '0;
            gy_q    <= '0;
        end else begin
            g_vld_q <= win_vld_q;
            g_eof_q <= win_vld_q && win_eof_q;
            g_thr_q <= win_thr_q;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
        end
    end

    always_comb begin
        abs_x = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
        abs_y = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
        mag   = abs_x + abs_y;
        sat   = (mag > 11'd255) ? 8'hFF : mag[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            out_edge_q  <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            out_valid_q <= g_vld_q;
            out_byte_q  <= g_vld_q ? sat : 8'h00;
            out_edge_q  <= g_vld_q && (sat > g_thr_q);
            out_eof_q   <= g_vld_q && g_eof_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign out_edge  = out_edge_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Scoreboard bench for sobel_edge_stream at 8x6: a reference Sobel over the driven
// image queues expected outputs, and a negedge monitor checks value, flags and latency.
module tb_sobel_edge_stream;

    localparam int W = 8;
    localparam int H = 6;
    localparam int PERIOD = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_sof;
    logic [7:0] in_byte, threshold;
    logic       out_valid, out_edge, out_eof;
    logic [7:0] out_byte;

    sobel_edge_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_byte   (in_byte),
        .threshold (threshold),
        .out_valid (out_valid),
        .out_byte  (out_byte),
        .out_edge  (out_edge),
        .out_eof   (out_eof)
    );

    always #(PERIOD/2) clk = ~clk;

    typedef struct {
        int     b;
        int     e;
        int     eof;
        longint t;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out    = 0;
    int   cur_img [H][W];
    int   rnd_img [H][W];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_mag(int r, int c);
        int p [3][3];
        int gx, gy, m;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = cur_img[r-2+i][c-2+j];
        gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    function automatic int gen_pix(int kind, int r, int c);
        case (kind)
            0: return 77;
            1: return (c < 4) ? 10 : 50;
            2: return (r < 3) ? 0 : 30;
            3: return (c < 4) ? 0 : 255;
            default: return rnd_img[r][c];
        endcase
    endfunction

    // Inputs change #1 after the edge; the pixel is accepted at the next posedge.
    task automatic drive_pix(input bit sof, input int r, input int c, input int v);
        exp_t e;
        cur_img[r][c] = v;
        in_valid = 1'b1;
        in_sof   = sof;
        in_byte  = 8'(v);
        @(posedge clk);
        if (r >= 2 && c >= 2) begin
            e.b   = ref_mag(r, c);
            e.e   = (e.b > int'(threshold)) ? 1 : 0;
            e.eof = (r == H-1 && c == W-1) ? 1 : 0;
            e.t   = $time;
            sb.push_back(e);
        end
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // stop_r/stop_c: abandon the frame just before that pixel (-1 runs it to completion).
    task automatic send_frame(input int kind, input int stall, input bit rnd_thr,
                              input int stop_r, input int stop_c);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                if (rnd_thr) threshold = 8'($urandom_range(0, 255));
                drive_pix(r == 0 && c == 0, r, c, gen_pix(kind, r, c));
                if (stall) idle(2);
            end
    endtask

    task automatic drain_and_count(input string tag, input int start, input int exp_n);
        idle(6);
        check({tag, "_left"}, sb.size(), 0);
        if (exp_n >= 0) check({tag, "_count"}, n_out - start, exp_n);
    endtask

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (out_valid) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("byte", out_byte, e.b);
                    check("edge", out_edge, e.e);
                    check("eof", out_eof, e.eof);
                    check("latency", $time - e.t, 2*PERIOD + PERIOD/2);
                end
            end else begin
                check("idle_zero", {out_byte, out_edge, out_eof}, 0);
            end
        end
    end

    initial begin
        int s;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_byte = '0; threshold = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                rnd_img[r][c] = $urandom_range(0, 255);
        idle(3);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_outs", {out_byte, out_edge, out_eof}, 0);
        rst = 1'b0;

        // IDLE must ignore pixels without in_sof
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_byte = 8'(i * 40);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        idle(3);

        s = n_out; threshold = 8'd0;
        send_frame(0, 0, 0, -1, -1);
        drain_and_count("flat", s, 24);

        s = n_out; threshold = 8'd100;
        send_frame(1, 0, 0, -1, -1);
        drain_and_count("vstep", s, 24);

        s = n_out; threshold = 8'd100;
        send_frame(2, 0, 0, -1, -1);
        drain_and_count("hstep", s, 24);

        s = n_out; threshold = 8'd255;
        send_frame(3, 0, 0, -1, -1);
        drain_and_count("sat", s, 24);

        s = n_out; threshold = 8'd100;
        send_frame(1, 1, 0, -1, -1);
        drain_and_count("stall", s, 24);

        s = n_out;
        send_frame(4, 0, 1, -1, -1);
        drain_and_count("random", s, 24);

        // Abort at (3,5): 9 interior outputs already triggered, then a full new frame
        s = n_out; threshold = 8'd100;
        send_frame(1, 0, 0, 3, 5);
        send_frame(4, 0, 1, -1, -1);
        drain_and_count("restart", s, 33);

        // Reset at (3,5): in-flight work discarded, headerless pixels ignored afterwards
        threshold = 8'd100;
        send_frame(1, 0, 0, 3, 5);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_outs", {out_byte, out_edge, out_eof}, 0);
        s = n_out;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_byte = 8'((i % 2) * 200);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain_and_count("postrst", s, 0);

        s = n_out;
        send_frame(2, 0, 0, -1, -1);
        drain_and_count("recover", s, 24);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
